// File: rtl/cpu_perf_counter.sv
// Saturating CPU event counters (cycles, jumps, branches, taken branches, bubbles)
// that freeze on halt, with a registered one-of-N readout port.
module cpu_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             halted,
  input  logic             jumped,
  input  logic             is_branch,
  input  logic             branched,
  input  logic             bubble,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] data_out,
  output logic             frozen,
  output logic [4:0]       sat
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q,   cyc_d;
  logic [CNT_W-1:0] jmp_q,   jmp_d;
  logic [CNT_W-1:0] br_q,    br_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] bub_q,   bub_d;
  logic [4:0]       sat_q,   sat_d;
  logic [CNT_W-1:0] data_q,  data_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic ev);
    logic [CNT_W-1:0] r;
    r = v;
    if (ev && (v != ALL_ONES)) r = v + ONE;
    return r;
  endfunction

  // Priority: clr, then en gate, then frozen hold, then halt capture, then count.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    jmp_d   = jmp_q;
    br_d    = br_q;
    taken_d = taken_q;
    bub_d   = bub_q;
    if (clr) begin
      state_d = ST_RUN;
      cyc_d   = '0;
      jmp_d   = '0;
      br_d    = '0;
      taken_d = '0;
      bub_d   = '0;
    end else if (en && (state_q == ST_RUN)) begin
      if (halted) begin
        state_d = ST_FROZEN;
      end else begin
        cyc_d   = sat_inc(cyc_q,   1'b1);
        jmp_d   = sat_inc(jmp_q,   jumped);
        br_d    = sat_inc(br_q,    is_branch);
        taken_d = sat_inc(taken_q, branched);
        bub_d   = sat_inc(bub_q,   bubble);
      end
    end
  end

  always_comb begin
    sat_d = {bub_d   == ALL_ONES,
             taken_d == ALL_ONES,
             br_d    == ALL_ONES,
             jmp_d   == ALL_ONES,
             cyc_d   == ALL_ONES};
  end

  // Readout muxes the post-update values so data_out tracks the counters directly.
  always_comb begin
    data_d = '0;
    case (sel)
      3'd0:    data_d = cyc_d;
      3'd1:    data_d = jmp_d;
      3'd2:    data_d = br_d;
      3'd3:    data_d = taken_d;
      3'd4:    data_d = bub_d;
      3'd5:    data_d = {{(CNT_W-1){1'b0}}, (state_d == ST_FROZEN)};
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cyc_q   <= '0;
      jmp_q   <= '0;
      br_q    <= '0;
      taken_q <= '0;
      bub_q   <= '0;
      sat_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      jmp_q   <= jmp_d;
      br_q    <= br_d;
      taken_q <= taken_d;
      bub_q   <= bub_d;
      sat_q   <= sat_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;
  assign frozen   = (state_q == ST_FROZEN);
  assign sat      = sat_q;

endmodule
